// File: rtl/limiter_pkg.sv
// Shared constants, state encoding and small gain helpers for the peak limiter.
// Gains are Q1.15 unsigned; unity is 0x8000.
package limiter_pkg;

  localparam int SAMPLE_W   = 24;
  localparam int GAIN_W     = 16;
  localparam int GAIN_FRAC  = 15;
  localparam int DIVIDEND_W = SAMPLE_W + GAIN_FRAC;
  localparam int DIV_ITERS  = 16;
  localparam int LATENCY    = 20;

  localparam logic [GAIN_W-1:0] GAIN_UNITY = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ATTACK,
    ST_HOLD,
    ST_RELEASE
  } lim_state_t;

  // -0x800000 has no positive twin, so it saturates to full-scale positive.
  function automatic logic [SAMPLE_W-1:0] abs_sat(input logic [SAMPLE_W-1:0] x);
    if (x == {1'b1, {(SAMPLE_W-1){1'b0}}}) return {1'b0, {(SAMPLE_W-1){1'b1}}};
    else if (x[SAMPLE_W-1])                return -x;
    else                                   return x;
  endfunction

  function automatic logic [GAIN_W-1:0] attack_gain(input logic [GAIN_W-1:0] gain,
                                                    input logic [GAIN_W-1:0] target,
                                                    input logic [GAIN_W-1:0] step);
    if (target >= gain)       return gain;
    if (step >= gain - target) return target;
    return gain - step;
  endfunction

  function automatic logic [GAIN_W-1:0] release_gain(input logic [GAIN_W-1:0] gain,
                                                     input logic [GAIN_W-1:0] step);
    logic [GAIN_W:0] sum;
    sum = {1'b0, gain} + {1'b0, step};
    return (sum >= {1'b0, GAIN_UNITY}) ? GAIN_UNITY : sum[GAIN_W-1:0];
  endfunction

endpackage

// File: rtl/limiter_divider.sv
// Serial restoring divider: one quotient bit per clock, first bit on the start edge,
// done pulses exactly DIV_ITERS cycles after start. Quotient must fit in GAIN_W bits.
module limiter_divider
  import limiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [SAMPLE_W-1:0]   divisor,
  output logic                  done,
  output logic [GAIN_W-1:0]     quotient
);

  localparam int CNT_W = $clog2(DIV_ITERS);

  logic [SAMPLE_W-1:0] rem_q, rem_d, rem_src;
  logic [GAIN_W-1:0]   low_q, low_d, low_src;
  logic [GAIN_W-1:0]   quo_q, quo_d, quo_src;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                active_q, active_d, done_q, done_d;
  logic [SAMPLE_W:0]   trial;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    rem_src  = start ? {1'b0, dividend[DIVIDEND_W-1:GAIN_W]} : rem_q;
    low_src  = start ? dividend[GAIN_W-1:0] : low_q;
    quo_src  = start ? '0 : quo_q;
    trial    = {rem_src, low_src[GAIN_W-1]};
    rem_d    = rem_q;
    low_d    = low_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    done_d   = 1'b0;
    if (start || active_q) begin
      if (trial >= {1'b0, divisor}) begin
        rem_d = SAMPLE_W'(trial - {1'b0, divisor});
        quo_d = {quo_src[GAIN_W-2:0], 1'b1};
      end else begin
        rem_d = trial[SAMPLE_W-1:0];
        quo_d = {quo_src[GAIN_W-2:0], 1'b0};
      end
      low_d = {low_src[GAIN_W-2:0], 1'b0};
      if (start) begin
        cnt_d    = CNT_W'(DIV_ITERS - 1);
        active_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          active_d = 1'b0;
          done_d   = 1'b1;
        end
      end
    end
  end

  // NOTE: flops take non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  // NOTE: datapath registers are left unreset; they are always loaded before being read.
  always_ff @(posedge clk) begin
    rem_q <= rem_d;
    low_q <= low_d;
    quo_q <= quo_d;
  end

  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/peak_limiter.sv
// Peak limiter: envelope follower, serial target-gain divider and attack/hold/release
// gain state machine, processing one sample at a time with a fixed 20-cycle latency.
module peak_limiter
  import limiter_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] audio_in,
  input  logic [SAMPLE_W-1:0] threshold,
  input  logic [GAIN_W-1:0]   attack_step,
  input  logic [GAIN_W-1:0]   release_step,
  input  logic [GAIN_W-1:0]   hold_samples,
  output logic                out_valid,
  output logic [SAMPLE_W-1:0] audio_out,
  output logic [GAIN_W-1:0]   gain_out,
  output logic                limit_active
);

  localparam int         PROD_W = SAMPLE_W + GAIN_FRAC;
  localparam logic [4:0] PH_ENV = 5'd1;
  localparam logic [4:0] PH_OUT = 5'(LATENCY - 1);

  logic [4:0]          phase_q, phase_d;
  logic                ready_q, ready_d;
  logic [SAMPLE_W-1:0] audio_q, audio_d, env_q, env_d, thr_q, thr_d;
  logic [GAIN_W-1:0]   atk_q, atk_d, rel_q, rel_d, hold_q, hold_d;
  logic [GAIN_W-1:0]   hcnt_q, hcnt_d, gain_q, gain_d;
  logic                en_q, en_d, over_q, over_d, div_start_q, div_start_d;
  lim_state_t          state_q, state_d;
  logic                out_valid_q, out_valid_d, limit_q, limit_d;
  logic [SAMPLE_W-1:0] audio_out_q, audio_out_d;
  logic [GAIN_W-1:0]   gain_out_q, gain_out_d;

  logic                accept, div_done;
  logic [GAIN_W-1:0]   div_quo, target;
  logic [SAMPLE_W-1:0] abs_v, env_new, env_eff;
  logic signed [PROD_W-1:0] product;

  limiter_divider u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start_q),
    .dividend ({thr_q, {GAIN_FRAC{1'b0}}}),
    .divisor  (env_q),
    .done     (div_done),
    .quotient (div_quo)
  );

  assign in_ready = ready_q && !rst;
  assign accept   = in_valid && in_ready;

  always_comb begin
    abs_v   = abs_sat(audio_q);
    env_new = (abs_v > env_q) ? abs_v : env_q - (env_q >> 8);
    env_eff = enable ? env_new : env_q;
    target  = over_q ? div_quo : GAIN_UNITY;
    product = PROD_W'($signed(audio_q)) * PROD_W'($signed({1'b0, gain_q}));

    phase_d     = phase_q;
    audio_d     = audio_q;
    env_d       = env_q;
    over_d      = over_q;
    thr_d       = thr_q;
    atk_d       = atk_q;
    rel_d       = rel_q;
    hold_d      = hold_q;
    en_d        = en_q;
    div_start_d = 1'b0;
    state_d     = state_q;
    gain_d      = gain_q;
    hcnt_d      = hcnt_q;
    out_valid_d = 1'b0;
    audio_out_d = audio_out_q;
    gain_out_d  = gain_out_q;
    limit_d     = limit_q;

    if (phase_q == '0) begin
      if (accept) begin
        phase_d = 5'd1;
        audio_d = audio_in;
      end
    end else if (phase_q == PH_OUT) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + 5'd1;
    end
    // Ready rises together with out_valid so the next sample can follow immediately.
    ready_d = (phase_d == '0);

    if (phase_q == PH_ENV) begin
      thr_d       = threshold;
      atk_d       = attack_step;
      rel_d       = release_step;
      hold_d      = hold_samples;
      en_d        = enable;
      env_d       = env_eff;
      over_d      = env_eff > threshold;
      div_start_d = 1'b1;
    end

    if (div_done && en_q) begin
      unique case (state_q)
        ST_IDLE: begin
          gain_d = over_q ? attack_gain(GAIN_UNITY, target, atk_q) : GAIN_UNITY;
          if (over_q) state_d = ST_ATTACK;
        end
        ST_ATTACK: begin
          gain_d = attack_gain(gain_q, target, atk_q);
          if (!over_q) begin
            state_d = ST_HOLD;
            hcnt_d  = hold_q;
          end
        end
        ST_HOLD: begin
          if (over_q) begin
            state_d = ST_ATTACK;
            gain_d  = attack_gain(gain_q, target, atk_q);
          end else if (hcnt_q == '0) begin
            state_d = ST_RELEASE;
          end else begin
            hcnt_d = hcnt_q - 1'b1;
          end
        end
        ST_RELEASE: begin
          if (over_q) begin
            state_d = ST_ATTACK;
            gain_d  = attack_gain(gain_q, target, atk_q);
          end else begin
            gain_d = release_gain(gain_q, rel_q);
            if (gain_d == GAIN_UNITY) state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (phase_q == PH_OUT) begin
      out_valid_d = 1'b1;
      audio_out_d = en_q ? SAMPLE_W'(product >>> GAIN_FRAC) : audio_q;
      gain_out_d  = en_q ? gain_q : GAIN_UNITY;
      limit_d     = en_q && (state_q != ST_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= '0;
      ready_q     <= 1'b0;
      env_q       <= '0;
      over_q      <= 1'b0;
      div_start_q <= 1'b0;
      state_q     <= ST_IDLE;
      gain_q      <= GAIN_UNITY;
      hcnt_q      <= '0;
      out_valid_q <= 1'b0;
      audio_out_q <= '0;
      gain_out_q  <= GAIN_UNITY;
      limit_q     <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      ready_q     <= ready_d;
      env_q       <= env_d;
      over_q      <= over_d;
      div_start_q <= div_start_d;
      state_q     <= state_d;
      gain_q      <= gain_d;
      hcnt_q      <= hcnt_d;
      out_valid_q <= out_valid_d;
      audio_out_q <= audio_out_d;
      gain_out_q  <= gain_out_d;
      limit_q     <= limit_d;
    end
  end

  always_ff @(posedge clk) begin
    audio_q <= audio_d;
    thr_q   <= thr_d;
    atk_q   <= atk_d;
    rel_q   <= rel_d;
    hold_q  <= hold_d;
    en_q    <= en_d;
  end

  assign out_valid    = out_valid_q;
  assign audio_out    = audio_out_q;
  assign gain_out     = gain_out_q;
  assign limit_active = limit_q;

endmodule

// File: tb/tb_peak_limiter.sv
// Self-checking bench for peak_limiter: a sample-level integer model predicts every
// output, directed vectors pin the model with hand-computed values.
module tb_peak_limiter;
  import limiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] audio_in = '0;
  logic [23:0] threshold = '0;
  logic [15:0] attack_step = '0;
  logic [15:0] release_step = '0;
  logic [15:0] hold_samples = '0;
  logic        out_valid;
  logic [23:0] audio_out;
  logic [15:0] gain_out;
  logic        limit_active;

  typedef struct {
    logic [23:0] audio;
    logic [15:0] gain;
    logic        lim;
    int          hs;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  exp_t e;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_hs = 0;
  int   n_ov;

  localparam int M_IDLE = 0, M_ATTACK = 1, M_HOLD = 2, M_RELEASE = 3;
  int m_env = 0, m_state = M_IDLE, m_gain = 32768, m_cnt = 0;

  logic [15:0] hr_gain [6] = '{16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h6000, 16'h8000};

  peak_limiter dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .audio_in     (audio_in),
    .threshold    (threshold),
    .attack_step  (attack_step),
    .release_step (release_step),
    .hold_samples (hold_samples),
    .out_valid    (out_valid),
    .audio_out    (audio_out),
    .gain_out     (gain_out),
    .limit_active (limit_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  function automatic int attack_m(input int g, input int t, input int s);
    if (t < g) return (g - s > t) ? g - s : t;
    return g;
  endfunction

  task automatic model_reset();
    m_env = 0; m_state = M_IDLE; m_gain = 32768; m_cnt = 0;
  endtask

  // One sample through the limiter rules, in plain integer arithmetic.
  task automatic model_step(input int s, input int thr, input int atk, input int rel,
                            input int hold, input bit en, output exp_t r);
    int     a, target;
    bit     over;
    longint prod;
    r.hs = 0;
    if (!en) begin
      r.audio = 24'(s); r.gain = 16'h8000; r.lim = 1'b0;
      return;
    end
    a = (s < 0) ? -s : s;
    if (a > 'h7FFFFF) a = 'h7FFFFF;
    m_env  = (a > m_env) ? a : m_env - m_env / 256;
    over   = m_env > thr;
    target = over ? int'((longint'(thr) * 32768) / m_env) : 32768;
    case (m_state)
      M_IDLE:
        if (over) begin m_state = M_ATTACK; m_gain = attack_m(32768, target, atk); end
        else m_gain = 32768;
      M_ATTACK: begin
        m_gain = attack_m(m_gain, target, atk);
        if (!over) begin m_state = M_HOLD; m_cnt = hold; end
      end
      M_HOLD:
        if (over) begin m_state = M_ATTACK; m_gain = attack_m(m_gain, target, atk); end
        else if (m_cnt == 0) m_state = M_RELEASE;
        else m_cnt--;
      default:
        if (over) begin m_state = M_ATTACK; m_gain = attack_m(m_gain, target, atk); end
        else begin
          m_gain = (m_gain + rel > 32768) ? 32768 : m_gain + rel;
          if (m_gain == 32768) m_state = M_IDLE;
        end
    endcase
    prod    = longint'(s) * m_gain;
    r.audio = 24'(prod >>> 15);
    r.gain  = 16'(m_gain);
    r.lim   = (m_state != M_IDLE);
  endtask

  // Offer one sample (leaves in_valid high); returns two cycles after the handshake.
  task automatic send(input logic [23:0] s, input logic [23:0] thr, input logic [15:0] atk,
                      input logic [15:0] rel, input logic [15:0] hold, input logic en,
                      input int gap, output exp_t r);
    int tries = 0;
    audio_in = s; threshold = thr; attack_step = atk; release_step = rel;
    hold_samples = hold; enable = en; in_valid = 1'b1;
    while (in_ready !== 1'b1 && tries < 64) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 64) begin
      check("handshake_timeout", 0, 1);
      r = '{audio: '0, gain: '0, lim: 1'b0, hs: 0};
      return;
    end
    model_step(int'($signed(s)), int'(thr), int'(atk), int'(rel), int'(hold), en, r);
    r.hs = cyc;
    exp_q.push_back(r);
    if (gap > 0) check("accept_spacing", cyc - last_hs, gap);
    last_hs = cyc;
    @(negedge clk);
    check("ready_low_cycle1", in_ready, 0);
    @(negedge clk);
  endtask

  task automatic drain();
    int t = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("latency", cyc - mon_e.hs, LATENCY);
        check("audio_out", audio_out, mon_e.audio);
        check("gain_out", gain_out, mon_e.gain);
        check("limit_active", limit_active, mon_e.lim);
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("ready_in_reset", in_ready, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_audio_out", audio_out, 24'h000000);
    check("rst_gain_out", gain_out, 16'h8000);
    check("rst_limit", limit_active, 0);
    check("ready_after_rst", in_ready, 1);

    send(24'h080000, 24'h100000, 16'h8000, 16'h0000, 16'h0000, 1'b1, 0, e);
    check("pin_below_audio", e.audio, 24'h080000);
    check("pin_below_gain", e.gain, 16'h8000);
    check("pin_below_lim", e.lim, 0);
    drain();

    send(24'h400000, 24'h200000, 16'h8000, 16'h0000, 16'h0000, 1'b1, 0, e);
    check("pin_attack_gain", e.gain, 16'h4000);
    check("pin_attack_audio", e.audio, 24'h200000);
    check("pin_attack_lim", e.lim, 1);
    drain();

    for (int i = 0; i < 6; i++) begin
      send(24'h000000, 24'h7FFFFF, 16'h8000, 16'h2000, 16'h0002, 1'b1, 0, e);
      check("pin_hold_release_gain", e.gain, hr_gain[i]);
      check("pin_hold_release_lim", e.lim, (i == 5) ? 0 : 1);
    end
    drain();

    send(24'h800000, 24'h400000, 16'h8000, 16'h0000, 16'h0000, 1'b1, 0, e);
    check("pin_negfs_gain", e.gain, 16'h4000);
    check("pin_negfs_audio", e.audio, 24'hC00000);
    drain();

    send(24'h7FFFFF, 24'h100000, 16'h8000, 16'h0000, 16'h0000, 1'b0, 0, e);
    check("pin_bypass_audio", e.audio, 24'h7FFFFF);
    check("pin_bypass_gain", e.gain, 16'h8000);
    check("pin_bypass_lim", e.lim, 0);
    send(24'hFFFFFB, 24'h000000, 16'h1000, 16'h0000, 16'h0000, 1'b1, LATENCY, e);
    check("pin_thr0_gain", e.gain, 16'h3000);
    check("pin_thr0_audio", e.audio, 24'hFFFFFE);
    drain();

    send(24'h123456, 24'h100000, 16'h0800, 16'h0400, 16'h0001, 1'b1, 0, e);
    send(24'hDCBA98, 24'h100000, 16'h0800, 16'h0400, 16'h0001, 1'b1, LATENCY, e);
    send(24'h345678, 24'h100000, 16'h0800, 16'h0400, 16'h0001, 1'b1, LATENCY, e);
    drain();

    send(24'h300000, 24'h100000, 16'h8000, 16'h0000, 16'h0000, 1'b1, 0, e);
    in_valid = 1'b0;
    while (cyc < e.hs + 10) @(negedge clk);
    if (exp_q.size() != 0) exp_q.delete(exp_q.size() - 1);
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_audio_out", audio_out, 24'h000000);
    check("midrst_gain_out", gain_out, 16'h8000);
    check("midrst_limit", limit_active, 0);
    check("midrst_ready", in_ready, 0);
    rst = 1'b0;
    n_ov = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid === 1'b1) n_ov++;
    end
    check("no_out_after_midrst", n_ov, 0);

    send(24'h080000, 24'h100000, 16'h8000, 16'h0000, 16'h0000, 1'b1, 0, e);
    check("pin_recover_gain", e.gain, 16'h8000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
